fifo_drain_router: RTL and testbench

//   Read side of the transaction-layer FIFO bank. Round-robin arbitration

---
 rtl/fifo_drain_router_pkg.sv | 21 ++
 rtl/fifo_drain_router_if.sv | 25 ++
 rtl/fifo_drain_router_rr_arbiter4.sv | 28 ++
 rtl/fifo_drain_router.sv | 106 ++++++++++
 tb/tb_fifo_drain_router.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_drain_router_pkg.sv
// Shared constants for the FIFO drain router: layer state encodings, word width
// and the route field position used by the FIFO bank and the packet builder.
package fifo_drain_router_pkg;

   localparam int DATA_W    = 12;
   localparam int N_SRC     = 4;
   localparam int N_DST     = 4;
   localparam int ROUTE_LSB = 8;

   typedef enum logic [3:0] {
      ST_RESET  = 4'b0001,
      ST_INIT   = 4'b0010,
      ST_IDLE   = 4'b0100,
      ST_ACTIVE = 4'b1000
   } layer_state_e;

   function automatic logic [1:0] route_of(input logic [DATA_W-1:0] word);
      return word[ROUTE_LSB+1:ROUTE_LSB];
   endfunction

endpackage

// File: rtl/fifo_drain_router_if.sv
// Bundle between the drain router and the source/destination FIFO banks;
// the router uses the master view, the FIFO side (or a bench) the slave view.
interface fifo_drain_router_if;

   logic [3:0]                                                      state;
   logic [fifo_drain_router_pkg::N_SRC-1:0]                         src_empty;
   logic [fifo_drain_router_pkg::N_SRC*fifo_drain_router_pkg::DATA_W-1:0] src_data;
   logic [fifo_drain_router_pkg::N_SRC-1:0]                         src_pop;
   logic [fifo_drain_router_pkg::N_DST-1:0]                         dst_almost_full;
   logic [fifo_drain_router_pkg::N_DST-1:0]                         dst_push;
   logic [fifo_drain_router_pkg::DATA_W-1:0]                        dst_data;
   logic                                                            idle;
   logic [7:0]                                                      fwd_count;

   modport master (
      input  state, src_empty, src_data, dst_almost_full,
      output src_pop, dst_push, dst_data, idle, fwd_count
   );

   modport slave (
      output state, src_empty, src_data, dst_almost_full,
      input  src_pop, dst_push, dst_data, idle, fwd_count
   );

endinterface

// File: rtl/fifo_drain_router_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: grants the first requester after ptr,
// wrapping cyclically; the requester at ptr itself has lowest priority.
module rr_arbiter4 (
   input  logic [3:0] i_req,
   input  logic [1:0] i_ptr,
   output logic [3:0] o_gnt,
   output logic [1:0] o_gnt_idx
);

   logic [1:0] w_idx;
   logic       w_found;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = i_ptr;
      w_idx     = '0;
      w_found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         w_idx = i_ptr + 2'(k);
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_gnt_idx    = w_idx;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_drain_router.sv
// Pops source FIFOs round-robin and pushes each word to the destination named by its
// route field, 2 cycles pop->push; any destination almost_full or a non-active state stops new pops.
module fifo_drain_router
   import fifo_drain_router_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_reset,
   fifo_drain_router_if.master io_bus
);

   logic [N_SRC-1:0]  r_src_pop;
   logic [1:0]        r_ptr;
   logic              r_cap_vld;
   logic [1:0]        r_cap_idx;
   logic [N_DST-1:0]  r_dst_push;
   logic [DATA_W-1:0] r_dst_data;
   logic [7:0]        r_fwd_count;
   logic              r_idle;

   logic [N_SRC-1:0]  w_src_pop_nxt;
   logic [1:0]        w_ptr_nxt;
   logic              w_cap_vld_nxt;
   logic [1:0]        w_cap_idx_nxt;
   logic [N_DST-1:0]  w_dst_push_nxt;
   logic [DATA_W-1:0] w_dst_data_nxt;
   logic [7:0]        w_fwd_count_nxt;
   logic              w_idle_nxt;

   logic              w_sync_rst;
   logic              w_pop_ok;
   logic [3:0]        w_gnt;
   logic [1:0]        w_gnt_idx;
   logic [DATA_W-1:0] w_cap_word;

   // Layer reset state behaves exactly like the reset pin.
   assign w_sync_rst = ~i_reset | (io_bus.state == ST_RESET);
   assign w_pop_ok   = (io_bus.state == ST_ACTIVE) &&
                       (io_bus.dst_almost_full == '0) &&
                       (io_bus.src_empty != '1);
   assign w_cap_word = io_bus.src_data[32'(r_cap_idx) * DATA_W +: DATA_W];

   rr_arbiter4 u_arb (
      .i_req     (~io_bus.src_empty),
      .i_ptr     (r_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   always_comb begin
      w_src_pop_nxt   = '0;
      w_ptr_nxt       = r_ptr;
      w_cap_vld_nxt   = |r_src_pop;
      w_cap_idx_nxt   = r_cap_idx;
      w_dst_push_nxt  = '0;
      w_dst_data_nxt  = r_dst_data;
      w_fwd_count_nxt = r_fwd_count;

      if (w_pop_ok) begin
         w_src_pop_nxt = w_gnt;
         w_ptr_nxt     = w_gnt_idx;
      end

      // r_ptr already names the source whose pop is currently asserted.
      if (|r_src_pop) begin
         w_cap_idx_nxt = r_ptr;
      end

      // Words in the capture stage always push, even once almost_full rises.
      if (r_cap_vld) begin
         w_dst_push_nxt  = 4'b0001 << route_of(w_cap_word);
         w_dst_data_nxt  = w_cap_word;
         w_fwd_count_nxt = r_fwd_count + 8'd1;
      end

      w_idle_nxt = ~|w_src_pop_nxt & ~w_cap_vld_nxt & ~|w_dst_push_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (w_sync_rst) begin
         r_src_pop   <= '0;
         r_ptr       <= 2'd3;
         r_cap_vld   <= 1'b0;
         r_cap_idx   <= '0;
         r_dst_push  <= '0;
         r_dst_data  <= '0;
         r_fwd_count <= '0;
         r_idle      <= 1'b1;
      end else begin
         r_src_pop   <= w_src_pop_nxt;
         r_ptr       <= w_ptr_nxt;
         r_cap_vld   <= w_cap_vld_nxt;
         r_cap_idx   <= w_cap_idx_nxt;
         r_dst_push  <= w_dst_push_nxt;
         r_dst_data  <= w_dst_data_nxt;
         r_fwd_count <= w_fwd_count_nxt;
         r_idle      <= w_idle_nxt;
      end
   end

   assign io_bus.src_pop   = r_src_pop;
   assign io_bus.dst_push  = r_dst_push;
   assign io_bus.dst_data  = r_dst_data;
   assign io_bus.fwd_count = r_fwd_count;
   assign io_bus.idle      = r_idle;

endmodule

// File: tb/tb_fifo_drain_router.sv
// Directed bench for fifo_drain_router: inputs change 1ns after posedge, outputs are checked there.
module tb_fifo_drain_router;
   import fifo_drain_router_pkg::*;

   logic i_clk;
   logic i_reset;
   int   n_checks;
   int   n_fail;

   fifo_drain_router_if bus ();

   fifo_drain_router dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .io_bus  (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Source i carries route i: 005, 115, 225, 335.
   localparam logic [47:0] WORDS = {12'h335, 12'h225, 12'h115, 12'h005};

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset             = 1'b0;
      bus.state           = ST_IDLE;
      bus.src_empty       = 4'b1111;
      bus.dst_almost_full = 4'b0000;
      bus.src_data        = WORDS;
      tick();
      i_reset = 1'b1;
   endtask

   task automatic test_reset();
      i_reset             = 1'b0;
      bus.state           = ST_ACTIVE;
      bus.src_empty       = 4'b0000;
      bus.dst_almost_full = 4'b0000;
      bus.src_data        = WORDS;
      tick();
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0000) begin n_fail++; $display("FAIL reset_pop got %b want 0000", bus.src_pop); end
      n_checks++;
      if (bus.dst_push !== 4'b0000) begin n_fail++; $display("FAIL reset_push got %b want 0000", bus.dst_push); end
      n_checks++;
      if (bus.fwd_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.fwd_count); end
      n_checks++;
      if (bus.idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", bus.idle); end
      bus.state     = ST_IDLE;
      bus.src_empty = 4'b1111;
      i_reset       = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      bus.src_data  = {12'h335, 12'h3A5, 12'h115, 12'h005};
      bus.state     = ST_ACTIVE;
      bus.src_empty = 4'b1011;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0100) begin n_fail++; $display("FAIL single_pop got %b want 0100", bus.src_pop); end
      bus.src_empty = 4'b1111;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0000 || bus.dst_push !== 4'b0000) begin
         n_fail++; $display("FAIL single_n1 got pop %b push %b want 0000 0000", bus.src_pop, bus.dst_push);
      end
      tick();
      n_checks++;
      if (bus.dst_push !== 4'b1000) begin n_fail++; $display("FAIL single_push got %b want 1000", bus.dst_push); end
      n_checks++;
      if (bus.dst_data !== 12'h3A5) begin n_fail++; $display("FAIL single_data got %h want 3a5", bus.dst_data); end
      n_checks++;
      if (bus.fwd_count !== 8'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", bus.fwd_count); end
      n_checks++;
      if (bus.idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", bus.idle); end
      tick();
      n_checks++;
      if (bus.idle !== 1'b1 || bus.dst_data !== 12'h3A5) begin
         n_fail++; $display("FAIL single_after got idle %b data %h want 1 3a5", bus.idle, bus.dst_data);
      end
      bus.src_data = WORDS;
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_pop;
      logic [3:0]  exp_push;
      logic [11:0] exp_word;
      logic [47:0] words;
      words = WORDS;
      do_reset();
      bus.state = ST_ACTIVE;
      for (int k = 0; k < 10; k++) begin
         bus.src_empty = (k < 8) ? 4'b0000 : 4'b1111;
         tick();
         exp_pop = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
         n_checks++;
         if (bus.src_pop !== exp_pop) begin n_fail++; $display("FAIL rr_pop[%0d] got %b want %b", k, bus.src_pop, exp_pop); end
         if (k >= 2) begin
            exp_push = 4'b0001 << ((k - 2) % 4);
            exp_word = words[((k - 2) % 4) * 12 +: 12];
            n_checks++;
            if (bus.dst_push !== exp_push || bus.dst_data !== exp_word) begin
               n_fail++;
               $display("FAIL rr_push[%0d] got %b/%h want %b/%h", k, bus.dst_push, bus.dst_data, exp_push, exp_word);
            end
         end
      end
      n_checks++;
      if (bus.fwd_count !== 8'd8) begin n_fail++; $display("FAIL rr_count got %0d want 8", bus.fwd_count); end
   endtask

   task automatic test_almost_full();
      do_reset();
      bus.state     = ST_ACTIVE;
      bus.src_empty = 4'b0000;
      tick();
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0010) begin n_fail++; $display("FAIL af_second_pop got %b want 0010", bus.src_pop); end
      bus.dst_almost_full = 4'b0010;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0000 || bus.dst_push !== 4'b0001) begin
         n_fail++; $display("FAIL af_first_push got pop %b push %b want 0000 0001", bus.src_pop, bus.dst_push);
      end
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0000 || bus.dst_push !== 4'b0010 || bus.dst_data !== 12'h115) begin
         n_fail++; $display("FAIL af_second_push got pop %b push %b data %h want 0000 0010 115", bus.src_pop, bus.dst_push, bus.dst_data);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (bus.src_pop !== 4'b0000 || bus.dst_push !== 4'b0000) begin
            n_fail++; $display("FAIL af_stall[%0d] got pop %b push %b want 0000 0000", k, bus.src_pop, bus.dst_push);
         end
      end
      bus.dst_almost_full = 4'b0000;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0100) begin n_fail++; $display("FAIL af_resume got %b want 0100", bus.src_pop); end
      bus.src_empty = 4'b1111;
      tick();
      tick();
      n_checks++;
      if (bus.fwd_count !== 8'd3) begin n_fail++; $display("FAIL af_count got %0d want 3", bus.fwd_count); end
   endtask

   task automatic test_state_change();
      do_reset();
      bus.state     = ST_ACTIVE;
      bus.src_empty = 4'b1101;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0010) begin n_fail++; $display("FAIL st_pop got %b want 0010", bus.src_pop); end
      bus.state = ST_IDLE;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0000) begin n_fail++; $display("FAIL st_idle_nopop got %b want 0000", bus.src_pop); end
      tick();
      n_checks++;
      if (bus.dst_push !== 4'b0010 || bus.dst_data !== 12'h115) begin
         n_fail++; $display("FAIL st_drain got push %b data %h want 0010 115", bus.dst_push, bus.dst_data);
      end
      tick();
      n_checks++;
      if (bus.idle !== 1'b1 || bus.dst_push !== 4'b0000) begin
         n_fail++; $display("FAIL st_idle_after got idle %b push %b want 1 0000", bus.idle, bus.dst_push);
      end
      foreach (bus.state[i]) begin end
      bus.state = 4'b1100;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0000) begin n_fail++; $display("FAIL st_nonhot got %b want 0000", bus.src_pop); end
      bus.state = ST_INIT;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0000) begin n_fail++; $display("FAIL st_init got %b want 0000", bus.src_pop); end
      bus.state = ST_ACTIVE;
      tick();
      n_checks++;
      if (bus.src_pop !== 4'b0010) begin n_fail++; $display("FAIL st_mid_pop got %b want 0010", bus.src_pop); end
      bus.src_empty = 4'b1111;
      i_reset       = 1'b0;
      tick();
      i_reset = 1'b1;
      tick();
      n_checks++;
      if (bus.dst_push !== 4'b0000 || bus.fwd_count !== 8'd0 || bus.idle !== 1'b1) begin
         n_fail++; $display("FAIL st_reset_drop got push %b count %0d idle %b want 0000 0 1", bus.dst_push, bus.fwd_count, bus.idle);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.state     = ST_ACTIVE;
      bus.src_empty = 4'b1110;
      for (int k = 0; k < 256; k++) tick();
      bus.src_empty = 4'b1111;
      tick();
      n_checks++;
      if (bus.fwd_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", bus.fwd_count); end
      tick();
      n_checks++;
      if (bus.fwd_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got %0d want 0", bus.fwd_count); end
      n_checks++;
      if (bus.dst_push !== 4'b0001 || bus.dst_data !== 12'h005) begin
         n_fail++; $display("FAIL wrap_last got push %b data %h want 0001 005", bus.dst_push, bus.dst_data);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      i_reset  = 1'b0;
      bus.state           = ST_IDLE;
      bus.src_empty       = 4'b1111;
      bus.dst_almost_full = 4'b0000;
      bus.src_data        = WORDS;
      test_reset();
      test_single();
      test_round_robin();
      test_almost_full();
      test_state_change();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
